cv32e40p_fetch_aligner: RTL and testbench

//  Sits between the prefetch stage's fetch valid/ready interface and the IF/ID pipeline register.

---
 rtl/cv32e40p_fetch_aligner.sv | 70 +++++++
 tb/tb_cv32e40p_fetch_aligner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fetch_aligner.sv
// cv32e40p_fetch_aligner: realigns word-aligned fetch data into one RV32IC instruction per handshake
// Ports: clk/rst (sync, active-high); fetch_valid_i/fetch_ready_o/fetch_rdata_i from prefetcher;
// if_valid_i/instr_valid_o/instr_aligned_o/instr_compressed_o/pc_o to IF/ID;
// branch_i/branch_addr_i and hwlp_jump_i/hwlp_addr_i redirect the stream.
module cv32e40p_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        if_valid_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_addr_i
);
  localparam logic [1:0] ALIGNED32         = 2'd0;
  localparam logic [1:0] MISALIGNED32      = 2'd1;
  localparam logic [1:0] MISALIGNED16      = 2'd2;
  localparam logic [1:0] BRANCH_MISALIGNED = 2'd3;
  logic [1:0]  state, state_n;
  logic [31:0] pc_q, pc_n, target;
  logic [15:0] h_q;
  logic        redirect, accept, lo32, hi32;
  assign lo32 = fetch_rdata_i[1:0] == 2'b11;
  assign hi32 = fetch_rdata_i[17:16] == 2'b11;
  assign pc_o = pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALIGNED32;
      pc_q  <= RESET_PC;
      h_q   <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      if (fetch_ready_o) h_q <= fetch_rdata_i[31:16];
    end
  end
  // A consumed word whose upper half begins a 32b instr leaves that half in h_q (MISALIGNED32);
  // a compressed upper half is issued from h_q without needing a new word (MISALIGNED16).
  always_comb begin
    target  = (branch_i ? branch_addr_i : hwlp_addr_i) & 32'hFFFF_FFFE;
    state_n = redirect ? (target[1] ? BRANCH_MISALIGNED : ALIGNED32) :
              (accept && (state == MISALIGNED16 || state == BRANCH_MISALIGNED)) ? ALIGNED32 :
              (fetch_ready_o && !(state == ALIGNED32 && lo32)) ? (hi32 ? MISALIGNED32 : MISALIGNED16) :
              state;
    pc_n    = redirect ? target : accept ? pc_q + (instr_compressed_o ? 32'd2 : 32'd4) : pc_q;
  end
  // BRANCH_MISALIGNED with a 32b instr in the upper half only buffers that half (discard cycle).
  always_comb begin
    redirect           = branch_i | hwlp_jump_i;
    instr_aligned_o    = state == MISALIGNED32      ? {fetch_rdata_i[15:0], h_q} :
                         state == MISALIGNED16      ? {16'h0, h_q} :
                         state == BRANCH_MISALIGNED ? {16'h0, fetch_rdata_i[31:16]} :
                         lo32                       ? fetch_rdata_i : {16'h0, fetch_rdata_i[15:0]};
    instr_compressed_o = instr_aligned_o[1:0] != 2'b11;
    instr_valid_o      = !rst && !redirect &&
                         (state == MISALIGNED16 || (fetch_valid_i && (state != BRANCH_MISALIGNED || !hi32)));
    accept             = instr_valid_o && if_valid_i;
    fetch_ready_o      = !rst && !redirect &&
                         ((accept && state != MISALIGNED16) ||
                          (state == BRANCH_MISALIGNED && hi32 && fetch_valid_i));
  end
endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// tb_cv32e40p_fetch_aligner: vector table, directed corner sequences and a randomized halfword-stream model
module tb_cv32e40p_fetch_aligner;
  logic        clk = 1'b0;
  logic        rst, fv, iv, br, hj;
  logic [31:0] w, ba, ha;
  logic        ready, valid, comp;
  logic [31:0] instr, pc;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  cv32e40p_fetch_aligner #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_valid_i(fv), .fetch_ready_o(ready), .fetch_rdata_i(w),
    .if_valid_i(iv), .instr_valid_o(valid), .instr_aligned_o(instr), .instr_compressed_o(comp),
    .pc_o(pc), .branch_i(br), .branch_addr_i(ba), .hwlp_jump_i(hj), .hwlp_addr_i(ha)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle();
    fv = 0; iv = 0; br = 0; hj = 0; w = 0; ba = 0; ha = 0;
  endtask
  task automatic do_reset();
    rst = 1; idle(); fv = 1; w = 32'h0000_0013;
    @(posedge clk); #1;
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_ready", {31'b0, ready}, 0);
    @(posedge clk); #1;
    rst = 0; idle();
  endtask
  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask
  typedef struct {
    logic fv; logic [31:0] w; logic iv; logic br;
    logic e_valid; logic [31:0] e_instr; logic e_comp; logic e_ready;
  } vec_t;
  vec_t tbl[6];
  // halfword memory seen by the random-stream model
  logic [15:0] mem [512];
  logic [31:0] m_pc, m_fa;
  logic        m_buf;
  function automatic logic [15:0] hwf(input logic [31:0] a);
    return mem[a[9:1]];
  endfunction
  function automatic logic avail(input logic [31:0] a, input logic f);
    return (m_buf && a == m_fa - 32'd2) || (f && (a == m_fa || a == m_fa + 32'd2));
  endfunction
  initial begin
    tbl[0] = '{1, 32'h0000_0013, 1, 0, 1, 32'h0000_0013, 0, 1};
    tbl[1] = '{1, 32'h4501_4505, 1, 0, 1, 32'h0000_4505, 1, 1};
    tbl[2] = '{0, 32'h4501_4505, 0, 0, 0, 32'h0,         0, 0};
    tbl[3] = '{1, 32'h0013_4505, 0, 0, 1, 32'h0000_4505, 1, 0};
    tbl[4] = '{1, 32'h0000_0013, 0, 1, 0, 32'h0,         0, 0};
    tbl[5] = '{1, 32'hABCD_1233, 1, 0, 1, 32'hABCD_1233, 0, 1};
    rst = 1; idle();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rst = 0; fv = tbl[i].fv; w = tbl[i].w; iv = tbl[i].iv; br = tbl[i].br; ba = 32'h40;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_ready", i), {31'b0, ready}, {31'b0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_pc", i), pc, 0);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d_comp", i), {31'b0, comp}, {31'b0, tbl[i].e_comp});
      end
      #1 rst = 1; idle();
      @(posedge clk); #1;
    end
    // T1
    do_reset();
    fv = 1; w = 32'h0000_0013; iv = 1; #1;
    chk("t1_instr", instr, 32'h13); chk("t1_comp", {31'b0, comp}, 0);
    chk("t1_pc", pc, 0); chk("t1_ready", {31'b0, ready}, 1);
    nxt(); #1;
    chk("t1_pc_next", pc, 4);
    // T2
    do_reset();
    fv = 1; w = 32'h4501_4505; iv = 1; #1;
    chk("t2_instr0", instr, 32'h4505); chk("t2_pc0", pc, 0); chk("t2_ready0", {31'b0, ready}, 1);
    nxt(); iv = 1; #1;
    chk("t2_valid1", {31'b0, valid}, 1); chk("t2_instr1", instr, 32'h4501);
    chk("t2_pc1", pc, 2); chk("t2_ready1", {31'b0, ready}, 0);
    nxt(); #1;
    chk("t2_pc2", pc, 4);
    // T3
    do_reset();
    fv = 1; w = 32'h0013_4505; iv = 1; #1;
    chk("t3_instr0", instr, 32'h4505); chk("t3_pc0", pc, 0);
    nxt(); fv = 1; w = 32'h1234_0000; iv = 1; #1;
    chk("t3_instr1", instr, 32'h13); chk("t3_pc1", pc, 2); chk("t3_ready1", {31'b0, ready}, 1);
    nxt(); iv = 1; #1;
    chk("t3_h_instr", instr, 32'h1234); chk("t3_h_valid", {31'b0, valid}, 1); chk("t3_pc2", pc, 6);
    // T4
    do_reset();
    br = 1; ba = 32'h102; fv = 1; w = 32'h0000_0013; #1;
    chk("t4_br_valid", {31'b0, valid}, 0); chk("t4_br_ready", {31'b0, ready}, 0);
    nxt(); fv = 1; w = 32'h4505_ABCD; iv = 1; #1;
    chk("t4_instr", instr, 32'h4505); chk("t4_pc", pc, 32'h102);
    chk("t4_comp", {31'b0, comp}, 1); chk("t4_ready", {31'b0, ready}, 1);
    nxt(); #1;
    chk("t4_pc_next", pc, 32'h104);
    // T4b
    do_reset();
    br = 1; ba = 32'h103; #1;
    nxt(); fv = 1; w = 32'h0013_ABCD; #1;
    chk("t4b_disc_valid", {31'b0, valid}, 0); chk("t4b_disc_ready", {31'b0, ready}, 1);
    nxt(); fv = 1; w = 32'h0000_0000; iv = 1; #1;
    chk("t4b_instr", instr, 32'h13); chk("t4b_pc", pc, 32'h102);
    // T5
    do_reset();
    fv = 1; w = 32'h4501_4505; iv = 1; #1;
    nxt(); br = 1; ba = 32'h200; hj = 1; ha = 32'h300; iv = 1; #1;
    chk("t5_valid", {31'b0, valid}, 0); chk("t5_ready", {31'b0, ready}, 0);
    nxt(); fv = 1; w = 32'h0000_0013; #1;
    chk("t5_pc", pc, 32'h200); chk("t5_aligned_instr", instr, 32'h13);
    chk("t5_aligned_valid", {31'b0, valid}, 1);
    // T6
    do_reset();
    fv = 1; w = 32'h0013_4505; iv = 1; #1;
    for (int i = 0; i < 3; i++) begin
      nxt(); fv = 1; w = 32'h1234_0000; #1;
      chk($sformatf("t6_stall%0d_instr", i), instr, 32'h13);
      chk($sformatf("t6_stall%0d_pc", i), pc, 2);
      chk($sformatf("t6_stall%0d_ready", i), {31'b0, ready}, 0);
    end
    rst = 1; #1;
    chk("t6_rst_valid", {31'b0, valid}, 0);
    @(posedge clk); #1;
    rst = 0; idle(); fv = 1; w = 32'h0000_0013; #1;
    chk("t6_rst_pc", pc, 0); chk("t6_rst_instr", instr, 32'h13);
    // randomized stream against a halfword-address model
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) mem[i][1:0] = 2'b11;
    end
    do_reset();
    m_pc = 0; m_fa = 0; m_buf = 0;
    for (int c = 0; c < 4000; c++) begin
      logic        redir, is32, e_valid, e_acc, e_ready;
      logic [15:0] lo;
      logic [31:0] tgt, len;
      fv = $urandom_range(0, 3) != 0;
      w  = fv ? {hwf(m_fa + 32'd2), hwf(m_fa)} : $urandom;
      br = $urandom_range(0, 29) == 0;
      hj = $urandom_range(0, 29) == 0;
      ba = $urandom_range(0, 1023);
      ha = $urandom_range(0, 1023);
      iv = 0;
      #1;
      iv = valid && ($urandom_range(0, 3) != 0);
      #1;
      redir   = br || hj;
      tgt     = (br ? ba : ha) & 32'hFFFF_FFFE;
      lo      = hwf(m_pc);
      is32    = lo[1:0] == 2'b11;
      len     = is32 ? 32'd4 : 32'd2;
      e_valid = !redir && avail(m_pc, fv) && (!is32 || avail(m_pc + 32'd2, fv));
      e_acc   = e_valid && iv;
      e_ready = !redir && fv && (e_acc ? (m_pc + len > m_fa) : (!e_valid && m_pc == m_fa + 32'd2));
      chk("rnd_valid", {31'b0, valid}, {31'b0, e_valid});
      chk("rnd_ready", {31'b0, ready}, {31'b0, e_ready});
      if (e_valid) begin
        chk("rnd_instr", instr, is32 ? {hwf(m_pc + 32'd2), lo} : {16'h0, lo});
        chk("rnd_pc", pc, m_pc);
        chk("rnd_comp", {31'b0, comp}, {31'b0, !is32});
      end
      @(posedge clk); #1;
      if (redir) begin
        m_pc = tgt; m_fa = tgt & 32'hFFFF_FFFC; m_buf = 0;
      end else begin
        if (e_acc) m_pc = m_pc + len;
        if (e_ready) begin m_fa = m_fa + 32'd4; m_buf = 1; end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
